// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - 4-bit MIPS-style ALU control codes accepted on the request port
//   - 2-bit mux-select encodings understood by the 1-bit ALU cell
//   - sequencer state enumeration
//   - decoded-control record produced by alu_ctrl_decode
// ----------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // Cell result-mux select
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Decoded control for one operation
    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       ci0;
        logic [1:0] op;
        logic       is_slt;
        logic       is_arith;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decoder from the 4-bit ALU control to the cell drive
// settings (invert flags, initial carry, mux select) plus op classification.
// Unknown codes are executed as AND and flagged illegal.
//   ctrl_i : 4-bit ALU control code
//   dec_o  : decoded-control record
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [3:0] ctrl_i,
    output dec_t       dec_o
);

    // Control-code lookup
    always_comb begin
        dec_o = '0;
        case (ctrl_i)
            CTRL_AND: begin
                dec_o.op = OP_AND;
            end
            CTRL_OR: begin
                dec_o.op = OP_OR;
            end
            CTRL_ADD: begin
                dec_o.op       = OP_ADD;
                dec_o.is_arith = 1'b1;
            end
            CTRL_SUB: begin
                dec_o.b_inv    = 1'b1;
                dec_o.ci0      = 1'b1;
                dec_o.op       = OP_ADD;
                dec_o.is_arith = 1'b1;
            end
            CTRL_SLT: begin
                dec_o.b_inv    = 1'b1;
                dec_o.ci0      = 1'b1;
                dec_o.op       = OP_LESS;
                dec_o.is_slt   = 1'b1;
                dec_o.is_arith = 1'b1;
            end
            CTRL_NOR: begin
                // ~a & ~b == ~(a | b)
                dec_o.a_inv = 1'b1;
                dec_o.b_inv = 1'b1;
                dec_o.op    = OP_AND;
            end
            default: begin
                dec_o.op      = OP_AND;
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// ----------------------------------------------------------------------------
// alu_serial_ctrl
// Bit-serial sequencer driving an external 1-bit ALU cell, LSB first, one
// operand bit per cycle, carrying the cell's carry-out between cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake; req_ctrl, req_a, req_b payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_result/zero/cout/ovf/illegal : response payload (registered)
//   cell_a_invert, cell_b_invert, cell_ci, cell_op, cell_a, cell_b,
//   cell_less             : drive to the cell (all 0 outside RUN)
//   cell_result, cell_co, cell_set : combinational cell outputs
// ----------------------------------------------------------------------------
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_ctrl,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_cout,
    output logic         rsp_ovf,
    output logic         rsp_illegal,
    output logic         cell_a_invert,
    output logic         cell_b_invert,
    output logic         cell_ci,
    output logic [1:0]   cell_op,
    output logic         cell_a,
    output logic         cell_b,
    output logic         cell_less,
    input  logic         cell_result,
    input  logic         cell_co,
    input  logic         cell_set
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    dec_t dec_s;

    state_t           state_q,    state_d;
    logic [W-1:0]     a_q,        a_d;
    logic [W-1:0]     b_q,        b_d;
    logic             a_inv_q,    a_inv_d;
    logic             b_inv_q,    b_inv_d;
    logic [1:0]       op_q,       op_d;
    logic             is_slt_q,   is_slt_d;
    logic             is_arith_q, is_arith_d;
    logic             illegal_q,  illegal_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             carry_q,    carry_d;
    logic [W-1:0]     res_q,      res_d;
    logic [W-1:0]     rsp_result_q,  rsp_result_d;
    logic             rsp_zero_q,    rsp_zero_d;
    logic             rsp_cout_q,    rsp_cout_d;
    logic             rsp_ovf_q,     rsp_ovf_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic             ovf_s;
    logic [W-1:0]     final_res_s;

    alu_ctrl_decode u_decode (
        .ctrl_i (req_ctrl),
        .dec_o  (dec_s)
    );

    // Next-state logic: accept, serial bit loop, response handshake
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        a_inv_d       = a_inv_q;
        b_inv_d       = b_inv_q;
        op_d          = op_q;
        is_slt_d      = is_slt_q;
        is_arith_d    = is_arith_q;
        illegal_d     = illegal_q;
        idx_d         = idx_q;
        carry_d       = carry_q;
        res_d         = res_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_cout_d    = rsp_cout_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_illegal_d = rsp_illegal_q;
        ovf_s         = 1'b0;
        final_res_s   = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d        = req_a;
                    b_d        = req_b;
                    a_inv_d    = dec_s.a_inv;
                    b_inv_d    = dec_s.b_inv;
                    op_d       = dec_s.op;
                    is_slt_d   = dec_s.is_slt;
                    is_arith_d = dec_s.is_arith;
                    illegal_d  = dec_s.illegal;
                    idx_d      = '0;
                    carry_d    = dec_s.ci0;
                    res_d      = '0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d[idx_q] = cell_result;
                carry_d      = cell_co;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // MSB cycle: carry-in vs carry-out of the sign cell gives
                    // signed overflow; SLT's true sign is set ^ overflow.
                    ovf_s = carry_q ^ cell_co;
                    if (is_slt_q) begin
                        final_res_s = {{(W-1){1'b0}}, cell_set ^ ovf_s};
                    end else begin
                        final_res_s = res_d;
                    end
                    rsp_result_d  = final_res_s;
                    rsp_zero_d    = (final_res_s == '0);
                    rsp_cout_d    = cell_co;
                    rsp_ovf_d     = is_arith_q & ovf_s;
                    rsp_illegal_d = illegal_q;
                    idx_d         = '0;
                    state_d       = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            a_inv_q       <= 1'b0;
            b_inv_q       <= 1'b0;
            op_q          <= 2'b00;
            is_slt_q      <= 1'b0;
            is_arith_q    <= 1'b0;
            illegal_q     <= 1'b0;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            res_q         <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_cout_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            a_inv_q       <= a_inv_d;
            b_inv_q       <= b_inv_d;
            op_q          <= op_d;
            is_slt_q      <= is_slt_d;
            is_arith_q    <= is_arith_d;
            illegal_q     <= illegal_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            res_q         <= res_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_cout_q    <= rsp_cout_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Cell drive: only active while stepping through bits
    always_comb begin
        cell_a_invert = 1'b0;
        cell_b_invert = 1'b0;
        cell_ci       = 1'b0;
        cell_op       = 2'b00;
        cell_a        = 1'b0;
        cell_b        = 1'b0;
        if (state_q == RUN) begin
            cell_a_invert = a_inv_q;
            cell_b_invert = b_inv_q;
            cell_ci       = carry_q;
            cell_op       = op_q;
            cell_a        = a_q[idx_q];
            cell_b        = b_q[idx_q];
        end else begin
            cell_op = 2'b00;
        end
    end

    assign cell_less   = 1'b0;
    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == DONE);
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_cout    = rsp_cout_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
